// File: rtl/microwave_cook_timer.sv
// Cook-time countdown feeding the microwave controller's done input; counts only while heat is on.
// Optional beep pulse on expiry is built when COOK_TIMER_BEEP_EN is defined.
//
// state     | meaning
// S_IDLE    | no cook time loaded, remaining=0
// S_ARMED   | cook time loaded, waiting for heat
// S_RUNNING | heat on, prescaler counting toward the next second
// S_PAUSED  | heat dropped mid-cook, prescaler and remaining held
// S_DONE    | time expired, done held until heat drops
module microwave_cook_timer #(
  parameter int W             = 8,
  parameter int TICKS_PER_SEC = 100,
  parameter int HEAT_BIT      = 1,
  parameter int BEEP_CYCLES   = 50
) (
  input  logic         clk,
  input  logic         sys_reset,
  input  logic [3:0]   States,
  input  logic         load,
  input  logic [W-1:0] load_secs,
  input  logic         clear,
  output logic         done,
  output logic         running,
  output logic [W-1:0] remaining
`ifdef COOK_TIMER_BEEP_EN
  ,
  output logic         beep
`endif
);

  localparam int PRE_W = $clog2(TICKS_PER_SEC);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_RUNNING = 3'd2,
    S_PAUSED  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [W-1:0]     rem_q, rem_d;
  logic             done_q, done_d;
  logic             running_q, running_d;
  logic             heat;
  logic             sec_tick;
  logic             states_unused;

  assign heat          = States[HEAT_BIT];
  assign states_unused = ^States;
  assign sec_tick      = (pre_q == PRE_W'(TICKS_PER_SEC - 1));

  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      rem_q     <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      rem_q     <= rem_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    rem_d   = rem_q;
    if (clear) begin
      state_d = S_IDLE;
      pre_d   = '0;
      rem_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load && (load_secs != '0)) begin
            state_d = S_ARMED;
            rem_d   = load_secs;
            pre_d   = '0;
          end
        end
        S_ARMED: begin
          // a reload on the same edge as heat rising still starts the run with the new value
          if (load && (load_secs == '0)) begin
            state_d = S_IDLE;
            rem_d   = '0;
            pre_d   = '0;
          end else begin
            if (load) begin
              rem_d = load_secs;
              pre_d = '0;
            end
            if (heat) state_d = S_RUNNING;
          end
        end
        S_RUNNING: begin
          // losing heat wins over a coincident second tick
          if (!heat) begin
            state_d = S_PAUSED;
          end else if (sec_tick) begin
            pre_d = '0;
            if (rem_q <= W'(1)) begin
              rem_d   = '0;
              state_d = S_DONE;
            end else begin
              rem_d = rem_q - W'(1);
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
        S_PAUSED: begin
          if (heat) state_d = S_RUNNING;
        end
        S_DONE: begin
          rem_d = '0;
          if (!heat) begin
            state_d = S_IDLE;
            pre_d   = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          pre_d   = '0;
          rem_d   = '0;
        end
      endcase
    end
    running_d = (state_d == S_RUNNING);
    done_d    = (state_d == S_DONE);
  end

  assign done      = done_q;
  assign running   = running_q;
  assign remaining = rem_q;

`ifdef COOK_TIMER_BEEP_EN
  localparam int BW = $clog2(BEEP_CYCLES + 1);

  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic          beep_q, beep_d;

  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      beep_cnt_q <= '0;
      beep_q     <= 1'b0;
    end else begin
      beep_cnt_q <= beep_cnt_d;
      beep_q     <= beep_d;
    end
  end

  // down-counter holds the cycles left after the current one
  always_comb begin
    beep_cnt_d = beep_cnt_q;
    beep_d     = beep_q;
    if (clear) begin
      beep_d     = 1'b0;
      beep_cnt_d = '0;
    end else if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      beep_d     = 1'b1;
      beep_cnt_d = BW'(BEEP_CYCLES - 1);
    end else if (beep_q) begin
      if (beep_cnt_q == '0) beep_d = 1'b0;
      else                  beep_cnt_d = beep_cnt_q - BW'(1);
    end
  end

  assign beep = beep_q;
`endif

endmodule

// File: tb/tb_microwave_cook_timer.sv
// Scoreboard bench for microwave_cook_timer with TICKS_PER_SEC=4; beep checks built with COOK_TIMER_BEEP_EN.
module tb_microwave_cook_timer;

  localparam int W    = 8;
  localparam int TPS  = 4;
  localparam int BEEP = 6;

  logic         clk;
  logic         sys_reset;
  logic [3:0]   States;
  logic         load;
  logic [W-1:0] load_secs;
  logic         clear;
  logic         done;
  logic         running;
  logic [W-1:0] remaining;
`ifdef COOK_TIMER_BEEP_EN
  logic         beep;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         h;
    logic         ld;
    logic [W-1:0] secs;
    logic         clr;
    logic [9:0]   exp;
  } stim_t;

  logic [9:0] sb[$];
  int         ib[$];

  microwave_cook_timer #(.W(W), .TICKS_PER_SEC(TPS), .HEAT_BIT(1), .BEEP_CYCLES(BEEP)) dut (
    .clk       (clk),
    .sys_reset (sys_reset),
    .States    (States),
    .load      (load),
    .load_secs (load_secs),
    .clear     (clear),
    .done      (done),
    .running   (running),
    .remaining (remaining)
`ifdef COOK_TIMER_BEEP_EN
    ,
    .beep      (beep)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // heat off keeps every other States bit high so only the heat bit matters
  function automatic stim_t mk(input logic h, input logic ld, input int secs, input logic clr,
                               input logic d, input logic r, input int rem);
    stim_t s;
    s.h    = h;
    s.ld   = ld;
    s.secs = W'(secs);
    s.clr  = clr;
    s.exp  = {d, r, W'(rem)};
    return s;
  endfunction

  task automatic drive(input logic h, input logic ld, input logic [W-1:0] secs, input logic clr);
    States    = h ? 4'b0010 : 4'b1101;
    load      = ld;
    load_secs = secs;
    clear     = clr;
    @(posedge clk);
    #1;
    load  = 1'b0;
    clear = 1'b0;
  endtask

  task automatic run_table(input string name, input stim_t t[$]);
    logic [9:0] e;
    foreach (t[i]) begin
      sb.push_back(t[i].exp);
      drive(t[i].h, t[i].ld, t[i].secs, t[i].clr);
      e = sb.pop_front();
      checks++;
      if ({done, running, remaining} !== e) begin
        errors++;
        $display("FAIL %s step %0d got done=%b running=%b remaining=%0d want done=%b running=%b remaining=%0d",
                 name, i, done, running, remaining, e[9], e[8], e[7:0]);
      end
    end
  endtask

  task automatic test_reset();
    logic [9:0] e;
    sys_reset = 1'b0;
    States = 4'b0000; load = 1'b0; load_secs = '0; clear = 1'b0;
    #12;
    sb.push_back(10'd0);
    e = sb.pop_front();
    checks++;
    if ({done, running, remaining} !== e) begin
      errors++;
      $display("FAIL reset got %b want %b", {done, running, remaining}, e);
    end
`ifdef COOK_TIMER_BEEP_EN
    checks++;
    if (beep !== 1'b0) begin
      errors++;
      $display("FAIL reset_beep got %b want 0", beep);
    end
`endif
    #6 sys_reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_countdown();
    stim_t t[$];
    t.push_back(mk(0, 1, 3, 0, 0, 0, 3));
    t.push_back(mk(1, 0, 0, 0, 0, 1, 3));
    for (int k = 1; k <= 12; k++)
      t.push_back(mk(1, 0, 0, 0, k == 12, k < 12, 3 - k / TPS));
    run_table("countdown", t);
  endtask

  task automatic test_done_hold();
    stim_t t[$];
    for (int k = 0; k < 20; k++)
      t.push_back(mk(1, k == 5, 7, 0, 1, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    run_table("done_hold", t);
  endtask

  task automatic test_pause();
    stim_t t[$];
    t.push_back(mk(0, 1, 2, 0, 0, 0, 2));
    t.push_back(mk(1, 0, 0, 0, 0, 1, 2));
    for (int k = 0; k < 3; k++) t.push_back(mk(1, 0, 0, 0, 0, 1, 2));
    for (int k = 0; k < 10; k++) t.push_back(mk(0, k == 3, 9, 0, 0, 0, 2));
    t.push_back(mk(1, 0, 0, 0, 0, 1, 2));
    for (int k = 1; k <= 4; k++) t.push_back(mk(1, 0, 0, 0, 0, 1, 1));
    t.push_back(mk(1, 0, 0, 0, 1, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    run_table("pause", t);
  endtask

  task automatic test_clear();
    stim_t t[$];
    t.push_back(mk(0, 1, 3, 0, 0, 0, 3));
    t.push_back(mk(1, 0, 0, 0, 0, 1, 3));
    for (int k = 1; k <= 4; k++) t.push_back(mk(1, 0, 0, 0, 0, 1, k == 4 ? 2 : 3));
    t.push_back(mk(1, 0, 0, 1, 0, 0, 0));
    for (int k = 0; k < 5; k++) t.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    run_table("clear", t);
  endtask

  task automatic test_load_rules();
    stim_t t[$];
    t.push_back(mk(0, 1, 0, 0, 0, 0, 0));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(0, 1, 4, 0, 0, 0, 4));
    t.push_back(mk(0, 1, 6, 0, 0, 0, 6));
    t.push_back(mk(1, 1, 5, 0, 0, 1, 5));
    t.push_back(mk(1, 1, 9, 0, 0, 1, 5));
    t.push_back(mk(1, 0, 0, 0, 0, 1, 5));
    t.push_back(mk(1, 0, 0, 0, 0, 1, 5));
    t.push_back(mk(1, 0, 0, 0, 0, 1, 4));
    t.push_back(mk(0, 0, 0, 1, 0, 0, 0));
    run_table("load_rules", t);
  endtask

  task automatic test_back_to_back();
    stim_t t[$];
    t.push_back(mk(0, 1, 1, 0, 0, 0, 1));
    t.push_back(mk(1, 0, 0, 0, 0, 1, 1));
    for (int k = 1; k <= 4; k++) t.push_back(mk(1, 0, 0, 0, k == 4, k < 4, k == 4 ? 0 : 1));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1, 1, 2, 0, 0, 0, 2));
    t.push_back(mk(1, 0, 0, 0, 0, 1, 2));
    t.push_back(mk(0, 0, 0, 1, 0, 0, 0));
    run_table("back_to_back", t);
  endtask

  task automatic test_async_reset();
    stim_t t[$];
    logic [9:0] e;
    t.push_back(mk(0, 1, 3, 0, 0, 0, 3));
    t.push_back(mk(1, 0, 0, 0, 0, 1, 3));
    t.push_back(mk(1, 0, 0, 0, 0, 1, 3));
    t.push_back(mk(1, 0, 0, 0, 0, 1, 3));
    run_table("async_pre", t);
    #2 sys_reset = 1'b0;
    #1;
    sb.push_back(10'd0);
    e = sb.pop_front();
    checks++;
    if ({done, running, remaining} !== e) begin
      errors++;
      $display("FAIL async_reset got %b want %b", {done, running, remaining}, e);
    end
    States = 4'b0000;
    #4 sys_reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

`ifdef COOK_TIMER_BEEP_EN
  task automatic test_beep();
    stim_t t[$];
    int n;
    int want;
    t.push_back(mk(0, 1, 1, 0, 0, 0, 1));
    t.push_back(mk(1, 0, 0, 0, 0, 1, 1));
    for (int k = 1; k <= 4; k++) t.push_back(mk(1, 0, 0, 0, k == 4, k < 4, k == 4 ? 0 : 1));
    run_table("beep_run", t);
    ib.push_back(BEEP);
    n = 0;
    while (beep === 1'b1 && n < 40) begin
      n++;
      drive(1, 0, 0, 0);
    end
    want = ib.pop_front();
    checks++;
    if (n !== want) begin
      errors++;
      $display("FAIL beep_len got %0d want %0d", n, want);
    end
    t.delete();
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(0, 1, 1, 0, 0, 0, 1));
    t.push_back(mk(1, 0, 0, 0, 0, 1, 1));
    for (int k = 1; k <= 4; k++) t.push_back(mk(1, 0, 0, 0, k == 4, k < 4, k == 4 ? 0 : 1));
    t.push_back(mk(1, 0, 0, 0, 1, 0, 0));
    run_table("beep_rerun", t);
    ib.push_back(1);
    want = ib.pop_front();
    checks++;
    if (int'(beep) !== want) begin
      errors++;
      $display("FAIL beep_restart got %b want %0d", beep, want);
    end
    drive(1, 0, 0, 1);
    ib.push_back(0);
    want = ib.pop_front();
    checks++;
    if (int'(beep) !== want) begin
      errors++;
      $display("FAIL beep_clear got %b want %0d", beep, want);
    end
    drive(0, 0, 0, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_countdown();
    test_done_hold();
    test_pause();
    test_clear();
    test_load_rules();
    test_back_to_back();
    test_async_reset();
`ifdef COOK_TIMER_BEEP_EN
    test_beep();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
